// File: rtl/parking_pkg.sv
// Shared state encoding, seven-segment table and decimal split helper
// for the parking lot controller.
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_WAIT_PASSWORD = 3'd1,
    S_WRONG_PASS    = 3'd2,
    S_RIGHT_PASS    = 3'd3,
    S_STOP          = 3'd4,
    S_LOCKED        = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } dec2_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d < 4'd10) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

  // Values never exceed 99, so tens is found by a short compare chain.
  function automatic dec2_t to_dec2(input logic [6:0] v);
    dec2_t r;
    r.tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (v >= 7'(10 * i)) r.tens = 4'(i);
    end
    r.ones = 4'(v - 7'(10 * r.tens));
    return r;
  endfunction

endpackage

// File: rtl/pw_checker.sv
// Serial password capture: digit shift register, digit index, idle timeout
// and single-cycle match/mismatch/timeout indications for the gate FSM.
module pw_checker
  import parking_pkg::*;
#(
  parameter int                           PW_DIGITS    = 4,
  parameter int                           DIGIT_W      = 4,
  parameter logic [PW_DIGITS*DIGIT_W-1:0] PASSWORD     = 16'h2468,
  parameter int                           WAIT_TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic               i_restart,
  input  logic               i_timing,
  input  logic               i_digit_valid,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic               o_match,
  output logic               o_mismatch,
  output logic               o_timeout
);

  localparam int PW_W  = PW_DIGITS * DIGIT_W;
  localparam int IDX_W = (PW_DIGITS > 1) ? $clog2(PW_DIGITS) : 1;
  localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_DIGITS - 1);

  logic [PW_W-1:0]  r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [TMR_W-1:0] r_timer;

  logic [PW_W-1:0]  w_base_shift;
  logic [PW_W-1:0]  w_shifted;
  logic [IDX_W-1:0] w_base_idx;
  logic             w_accept;
  logic             w_last;

  // A restart treats the incoming digit as the first of a fresh entry.
  always_comb begin
    w_base_shift = i_restart ? '0 : r_shift;
    w_base_idx   = i_restart ? '0 : r_idx;
    w_shifted    = (w_base_shift << DIGIT_W) | PW_W'(i_digit);
    w_accept     = i_enable & i_digit_valid;
    w_last       = (w_base_idx == LAST_IDX);
    o_match      = w_accept & w_last & (w_shifted == PASSWORD);
    o_mismatch   = w_accept & w_last & (w_shifted != PASSWORD);
    o_timeout    = i_timing & ~i_digit_valid & (r_timer == TMR_W'(WAIT_TIMEOUT - 1));
  end

  // NOTE: non-blocking assignments so every register here sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_timer <= '0;
    end else begin
      if (i_clear) begin
        r_shift <= '0;
        r_idx   <= '0;
      end else if (w_accept) begin
        r_shift <= w_shifted;
        r_idx   <= w_last ? '0 : w_base_idx + 1'b1;
      end
      if (!i_timing || i_digit_valid) begin
        r_timer <= '0;
      end else if (r_timer != TMR_W'(WAIT_TIMEOUT)) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Single-gate parking controller: password-gated entry, tailgater stop,
// lockout after repeated failures, occupancy tracking and free-slot display.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int                           CAPACITY     = 8,
  parameter int                           PW_DIGITS    = 4,
  parameter int                           DIGIT_W      = 4,
  parameter logic [PW_DIGITS*DIGIT_W-1:0] PASSWORD     = 16'h2468,
  parameter int                           MAX_TRIES    = 3,
  parameter int                           LOCK_CYCLES  = 16,
  parameter int                           WAIT_TIMEOUT = 32,
  localparam int                          OCC_W        = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_entrance,
  input  logic               sensor_exit,
  input  logic               car_leave,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               GREEN_LED,
  output logic               RED_LED,
  output logic [6:0]         HEX_1,
  output logic [6:0]         HEX_2,
  output logic               full,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam dec2_t RST_DEC = to_dec2(7'(CAPACITY));

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TRY_W-1:0]  r_tries;
  logic [TRY_W-1:0]  w_tries_nxt;
  logic [TRY_W-1:0]  w_tries_inc;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_stop_full;

  logic              w_clear;
  logic              w_enable;
  logic              w_restart;
  logic              w_timing;
  logic              w_match;
  logic              w_mismatch;
  logic              w_timeout;

  logic              w_inc;
  logic [OCC_W-1:0]  w_occ_nxt;
  logic              w_full_nxt;
  dec2_t             w_free_dec;
  logic              w_green_nxt;
  logic              w_red_nxt;

  always_comb begin
    w_clear   = (r_state == S_IDLE) || (r_state == S_RIGHT_PASS) || (r_state == S_LOCKED);
    w_restart = (r_state == S_WRONG_PASS);
    w_timing  = (r_state == S_WAIT_PASSWORD);
    w_enable  = (r_state == S_WAIT_PASSWORD)
             || ((r_state == S_WRONG_PASS) && (r_tries != TRY_W'(MAX_TRIES)))
             || ((r_state == S_STOP) && !r_stop_full);
  end

  pw_checker #(
    .PW_DIGITS   (PW_DIGITS),
    .DIGIT_W     (DIGIT_W),
    .PASSWORD    (PASSWORD),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_pw_checker (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_enable     (w_enable),
    .i_restart    (w_restart),
    .i_timing     (w_timing),
    .i_digit_valid(digit_valid),
    .i_digit      (digit),
    .o_match      (w_match),
    .o_mismatch   (w_mismatch),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tries     <= '0;
      r_lock_cnt  <= '0;
      r_stop_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tries     <= w_tries_nxt;
      r_lock_cnt  <= (r_state == S_LOCKED) ? r_lock_cnt + 1'b1 : '0;
      r_stop_full <= (r_state == S_STOP) ? r_stop_full : w_full_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_tries_inc = (r_tries == TRY_W'(MAX_TRIES)) ? r_tries : r_tries + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (sensor_entrance && !full) w_state_nxt = S_WAIT_PASSWORD;
      end
      S_WAIT_PASSWORD: begin
        if (!sensor_entrance) begin
          w_state_nxt = S_IDLE;
        end else if (w_match) begin
          w_state_nxt = S_RIGHT_PASS;
          w_tries_nxt = '0;
        end else if (w_mismatch) begin
          w_state_nxt = S_WRONG_PASS;
          w_tries_nxt = w_tries_inc;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRONG_PASS: begin
        if (r_tries == TRY_W'(MAX_TRIES)) begin
          w_state_nxt = S_LOCKED;
        end else if (!sensor_entrance) begin
          w_state_nxt = S_IDLE;
        end else if (w_match) begin
          w_state_nxt = S_RIGHT_PASS;
          w_tries_nxt = '0;
        end else if (w_mismatch) begin
          w_tries_nxt = w_tries_inc;
        end else if (digit_valid) begin
          w_state_nxt = S_WAIT_PASSWORD;
        end
      end
      S_RIGHT_PASS: begin
        if (sensor_exit) w_state_nxt = sensor_entrance ? S_STOP : S_IDLE;
      end
      S_STOP: begin
        if (!sensor_entrance) begin
          w_state_nxt = S_IDLE;
        end else if (w_match) begin
          w_state_nxt = S_RIGHT_PASS;
          w_tries_nxt = '0;
        end else if (w_mismatch) begin
          w_state_nxt = S_WRONG_PASS;
          w_tries_nxt = w_tries_inc;
        end
      end
      S_LOCKED: begin
        if (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_tries_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A car entering and one leaving in the same cycle cancel out.
  always_comb begin
    w_inc = (r_state == S_RIGHT_PASS) && sensor_exit && (occupancy != OCC_W'(CAPACITY));
    w_occ_nxt = occupancy;
    if (w_inc && car_leave) begin
      w_occ_nxt = occupancy;
    end else if (w_inc) begin
      w_occ_nxt = occupancy + 1'b1;
    end else if (car_leave && (occupancy != '0)) begin
      w_occ_nxt = occupancy - 1'b1;
    end
    w_full_nxt = (w_occ_nxt == OCC_W'(CAPACITY));
    w_free_dec = to_dec2(7'(CAPACITY) - 7'(w_occ_nxt));
  end

  always_comb begin
    w_green_nxt = 1'b0;
    w_red_nxt   = 1'b0;
    case (w_state_nxt)
      S_IDLE:                             w_red_nxt = sensor_entrance & w_full_nxt;
      S_WAIT_PASSWORD, S_STOP, S_LOCKED:  w_red_nxt = 1'b1;
      S_WRONG_PASS:                       w_red_nxt = (r_state == S_WRONG_PASS) ? ~RED_LED : 1'b1;
      S_RIGHT_PASS:                       w_green_nxt = 1'b1;
      default:                            w_red_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
      full      <= 1'b0;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= seg_of(RST_DEC.tens);
      HEX_2     <= seg_of(RST_DEC.ones);
    end else begin
      occupancy <= w_occ_nxt;
      full      <= w_full_nxt;
      GREEN_LED <= w_green_nxt;
      RED_LED   <= w_red_nxt;
      HEX_1     <= seg_of(w_free_dec.tens);
      HEX_2     <= seg_of(w_free_dec.ones);
    end
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed scoreboard bench for parking_lot_ctrl: expectations are queued as
// stimulus is driven and compared one clock later against the DUT outputs.
module tb_parking_lot_ctrl;

  typedef enum int {SIG_GREEN, SIG_RED, SIG_FULL, SIG_OCC, SIG_HEX1, SIG_HEX2} sig_t;

  typedef struct {
    string      tag;
    sig_t       sig;
    logic [6:0] val;
  } exp_t;

  localparam int CAP = 8;

  logic       clk;
  logic       reset;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic       car_leave;
  logic       digit_valid;
  logic [3:0] digit;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;
  logic       full;
  logic [3:0] occupancy;

  exp_t       sb[$];
  int         n_cmp;
  int         n_bad;
  int         m_occ;
  logic [6:0] seg_ref [10];

  parking_lot_ctrl #(
    .CAPACITY    (CAP),
    .PW_DIGITS   (4),
    .DIGIT_W     (4),
    .PASSWORD    (16'h2468),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (16),
    .WAIT_TIMEOUT(32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sensor_entrance(sensor_entrance),
    .sensor_exit    (sensor_exit),
    .car_leave      (car_leave),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .GREEN_LED      (GREEN_LED),
    .RED_LED        (RED_LED),
    .HEX_1          (HEX_1),
    .HEX_2          (HEX_2),
    .full           (full),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  function automatic logic [6:0] observe(input sig_t s);
    case (s)
      SIG_GREEN: return {6'b0, GREEN_LED};
      SIG_RED:   return {6'b0, RED_LED};
      SIG_FULL:  return {6'b0, full};
      SIG_OCC:   return {3'b0, occupancy};
      SIG_HEX1:  return HEX_1;
      SIG_HEX2:  return HEX_2;
      default:   return 7'h7f;
    endcase
  endfunction

  task automatic expect_val(input sig_t s, input logic [6:0] v, input string tag);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_display(input string tag);
    expect_val(SIG_OCC,  7'(m_occ), {tag, "_occ"});
    expect_val(SIG_FULL, {6'b0, m_occ == CAP}, {tag, "_full"});
    expect_val(SIG_HEX1, seg_ref[(CAP - m_occ) / 10], {tag, "_hex1"});
    expect_val(SIG_HEX2, seg_ref[(CAP - m_occ) % 10], {tag, "_hex2"});
  endtask

  task automatic check(input exp_t e);
    logic [6:0] o;
    o = observe(e.sig);
    n_cmp++;
    assert (o === e.val) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", e.tag, o, e.val);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    digit_valid = 1'b0;
    sensor_exit = 1'b0;
    car_leave   = 1'b0;
  endtask

  // Drives the first three digits with a clock each; the last digit is left
  // on the inputs so the caller can queue expectations before its clock.
  task automatic key_seq(input logic [15:0] pw);
    for (int i = 3; i >= 1; i--) begin
      digit       = pw[i*4 +: 4];
      digit_valid = 1'b1;
      tick();
    end
    digit       = pw[3:0];
    digit_valid = 1'b1;
  endtask

  task automatic do_entry(input logic with_leave, input string tag);
    sensor_entrance = 1'b1;
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd1, {tag, "_green"});
    tick();
    sensor_exit     = 1'b1;
    sensor_entrance = 1'b0;
    car_leave       = with_leave;
    if (!with_leave) m_occ++;
    push_display(tag);
    tick();
  endtask

  initial begin
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    n_cmp = 0;
    n_bad = 0;
    m_occ = 0;
    reset = 1'b1;
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    car_leave       = 1'b0;
    digit_valid     = 1'b0;
    digit           = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_val(SIG_GREEN, 7'd0, "rst_green");
    expect_val(SIG_RED,   7'd0, "rst_red");
    push_display("rst");
    tick();
    reset = 1'b0;

    // Correct entry, car passes in, gate closes
    sensor_entrance = 1'b1;
    expect_val(SIG_RED,   7'd1, "wait_red");
    expect_val(SIG_GREEN, 7'd0, "wait_green");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd1, "right_green");
    expect_val(SIG_RED,   7'd0, "right_red");
    tick();
    sensor_exit     = 1'b1;
    sensor_entrance = 1'b0;
    m_occ = 1;
    expect_val(SIG_GREEN, 7'd0, "entry1_green");
    expect_val(SIG_RED,   7'd0, "entry1_red");
    push_display("entry1");
    tick();

    // Three wrong passwords lead to lockout
    sensor_entrance = 1'b1;
    tick();
    key_seq(16'h1111);
    expect_val(SIG_RED,   7'd1, "wrong1_red");
    expect_val(SIG_GREEN, 7'd0, "wrong1_green");
    tick();
    expect_val(SIG_RED, 7'd0, "wrong1_blink_lo");
    tick();
    expect_val(SIG_RED, 7'd1, "wrong1_blink_hi");
    tick();
    key_seq(16'h1111);
    expect_val(SIG_RED, 7'd1, "wrong2_red");
    tick();
    expect_val(SIG_RED, 7'd0, "wrong2_blink_lo");
    tick();
    key_seq(16'h1111);
    expect_val(SIG_RED, 7'd1, "wrong3_red");
    tick();
    sensor_entrance = 1'b0;
    expect_val(SIG_RED, 7'd1, "locked_red");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd0, "locked_ignores_digits");
    expect_val(SIG_RED,   7'd1, "locked_red_steady");
    tick();
    repeat (10) tick();
    expect_val(SIG_RED, 7'd1, "locked_last_cycle");
    tick();
    expect_val(SIG_RED, 7'd0, "lock_released");
    tick();

    // Tries cleared by lockout: a single wrong entry blinks instead of locking
    sensor_entrance = 1'b1;
    tick();
    key_seq(16'h1111);
    expect_val(SIG_RED, 7'd1, "retry_wrong_red");
    tick();
    expect_val(SIG_RED, 7'd0, "tries_cleared_blink");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd1, "retry_right_green");
    tick();

    // Tailgater: exit with entrance still occupied goes to STOP
    sensor_exit = 1'b1;
    m_occ = 2;
    expect_val(SIG_RED,   7'd1, "stop_red");
    expect_val(SIG_GREEN, 7'd0, "stop_green");
    push_display("tailgate");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd1, "stop_right_green");
    tick();
    sensor_exit     = 1'b1;
    sensor_entrance = 1'b0;
    m_occ = 3;
    push_display("tailgate_in");
    tick();

    // Same-cycle entry and leave, then fill the lot
    do_entry(1'b1, "net_zero");
    while (m_occ < CAP) do_entry(1'b0, "fill");

    sensor_entrance = 1'b1;
    expect_val(SIG_RED, 7'd1, "full_red");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd0, "full_no_entry");
    expect_val(SIG_RED,   7'd1, "full_red_hold");
    tick();
    sensor_entrance = 1'b0;
    car_leave = 1'b1;
    m_occ = CAP - 1;
    expect_val(SIG_RED, 7'd0, "leave_red");
    push_display("leave_from_full");
    tick();

    // Drain, then abandoned entry times out
    while (m_occ > 0) begin
      car_leave = 1'b1;
      m_occ--;
      tick();
    end
    push_display("drained");
    sensor_entrance = 1'b1;
    tick();
    digit = 4'd2;
    digit_valid = 1'b1;
    tick();
    digit = 4'd4;
    digit_valid = 1'b1;
    tick();
    repeat (30) tick();
    expect_val(SIG_RED, 7'd1, "timeout_pre");
    tick();
    expect_val(SIG_RED, 7'd0, "timeout_idle");
    tick();
    expect_val(SIG_RED, 7'd1, "timeout_rearm");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd1, "after_timeout_green");
    tick();
    sensor_exit     = 1'b1;
    sensor_entrance = 1'b0;
    car_leave       = 1'b1;
    push_display("net_zero_at_empty");
    tick();
    car_leave = 1'b1;
    push_display("leave_at_zero");
    tick();

    // Asynchronous reset mid-entry
    sensor_entrance = 1'b1;
    tick();
    digit = 4'd2;
    digit_valid = 1'b1;
    tick();
    #3;
    reset = 1'b1;
    #1;
    expect_val(SIG_RED,   7'd0, "async_rst_red");
    expect_val(SIG_GREEN, 7'd0, "async_rst_green");
    drain();
    #1;
    reset = 1'b0;
    expect_val(SIG_RED, 7'd1, "post_rst_wait_red");
    tick();
    key_seq(16'h2468);
    expect_val(SIG_GREEN, 7'd1, "post_rst_green");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_lot_ctrl.md
Name: parking_lot_ctrl

Overview:
- Parametrised successor to the single-gate parking controller.
- Admits cars through one entrance gate after a multi-digit password is entered serially.
- Tracks lot occupancy up to CAPACITY, locks the gate after repeated wrong passwords, and times out abandoned entries.
- Shows free-slot count on two seven-segment digits; sits between the gate sensors/keypad and the LED/HEX board outputs.

Parameters:
- CAPACITY, 8: number of parking slots, 1..99.
- PW_DIGITS, 4: password length in digits, 1..8.
- DIGIT_W, 4: width of one keypad digit.
- PASSWORD, 16'h2468: expected password, PW_DIGITS*DIGIT_W bits; first digit entered is in the MS digit position.
- MAX_TRIES, 3: consecutive wrong passwords that trigger lockout.
- LOCK_CYCLES, 16: lockout duration in clk cycles.
- WAIT_TIMEOUT, 32: cycles allowed in WAIT_PASSWORD without a digit before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sensor_entrance  in  1  car present at gate.
- sensor_exit  in  1  car has passed gate into lot.
- car_leave  in  1  one-cycle pulse: a car left the lot.
- digit_valid  in  1  keypad digit strobe, one cycle per digit.
- digit  in  DIGIT_W  keypad digit value.
- GREEN_LED  out  1  gate open.
- RED_LED  out  1  gate closed / error.
- HEX_1  out  7  free-slot tens digit, active-low segments {g..a}.
- HEX_2  out  7  free-slot ones digit, active-low segments.
- full  out  1  occupancy == CAPACITY.
- occupancy  out  $clog2(CAPACITY+1)  cars in lot.

Behaviour:
- Single clock domain, clk. reset is asynchronous and active-high; it forces every register and registered output to its reset value immediately.
- All outputs registered; each reflects state/counters one cycle after the causing edge.
- Reset values:
  - state=IDLE, occupancy=0, full=0, tries=0.
  - GREEN_LED=0, RED_LED=0.
  - HEX_1/HEX_2 show CAPACITY (e.g. "0","8").
- FSM states: IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, LOCKED.
- IDLE:
  - sensor_entrance=1 and !full -> WAIT_PASSWORD; clear digit index and shift register.
  - sensor_entrance=1 and full -> stay IDLE; RED_LED=1 while sensor high.
- WAIT_PASSWORD (RED=1, GREEN=0):
  - Each digit_valid shifts digit in and increments the index.
  - On the PW_DIGITS-th digit: compare. Match -> RIGHT_PASS, tries=0. Mismatch -> WRONG_PASS, tries+1.
  - Timeout counter resets on every digit_valid. Reaching WAIT_TIMEOUT -> IDLE, tries unchanged.
  - sensor_entrance falling to 0 -> IDLE (car left).
- WRONG_PASS (RED blinks, toggling every cycle; GREEN=0):
  - tries==MAX_TRIES -> LOCKED.
  - Otherwise the next digit_valid restarts entry: that digit is index 0, state -> WAIT_PASSWORD.
- LOCKED (RED=1 steady):
  - All digit_valid ignored.
  - After LOCK_CYCLES cycles -> IDLE, tries=0.
- RIGHT_PASS (GREEN=1, RED=0):
  - sensor_exit=1: occupancy+1. Then sensor_entrance=1 -> STOP (tailgater); sensor_entrance=0 -> IDLE.
- STOP (RED=1, GREEN=0):
  - Tailgater must enter a fresh password. Digits are handled as in WAIT_PASSWORD: match -> RIGHT_PASS, mismatch -> WRONG_PASS.
  - If full at entry to STOP, all digits are ignored; the state holds until sensor_entrance=0, then -> IDLE.
- Occupancy arithmetic:
  - Never exceeds CAPACITY; never underflows. car_leave at occupancy 0 is ignored.
  - Same-cycle increment and car_leave: net 0.
  - full recomputed from the next occupancy value.
- Display: free = CAPACITY - occupancy. HEX_1 = seg(free/10), HEX_2 = seg(free%10). The divide is a small constant-bounded subtractor/LUT; CAPACITY<=99.
- digit_valid in IDLE, RIGHT_PASS or LOCKED is ignored.
- Reset mid-entry discards partial digits and the tries count.

Decomposition:
- Package parking_pkg:
  - state enum and encodings.
  - 7-segment active-low constant table for 0-9.
  - seg_of(digit) function.
- One sub-module, pw_checker: digit shift register, index counter, timeout counter, match/mismatch pulses.
- FSM, occupancy counter and display stay in the top.

Test Plan:
- Reset, no stimulus -> occupancy=0, full=0, HEX_1=7'b1000000 ("0"), HEX_2=7'b0000000 ("8"), both LEDs 0.
- sensor_entrance=1, digits 2,4,6,8, then sensor_exit pulse, sensor_entrance=0 -> GREEN=1 the cycle after the last digit; occupancy=1; HEX_2 shows "7"; FSM back to IDLE.
- Three wrong sequences 1,1,1,1 -> WRONG_PASS twice, then LOCKED; digits 2,4,6,8 during lock ignored; IDLE after 16 cycles with tries=0.
- After a correct entry, sensor_exit with sensor_entrance still 1 -> STOP with RED=1; a correct password -> RIGHT_PASS, occupancy increments again.
- Fill to 8 cars -> full=1, HEX shows "00"; sensor_entrance -> FSM stays IDLE with RED=1; a car_leave pulse -> occupancy=7, full=0.
- Enter 2 digits then wait 32 idle cycles -> IDLE; a car_leave at occupancy=0 -> occupancy stays 0.
